// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 window generator feeding the Sobel 3x3 MAC.
//
// Accepts one raster-order pixel per in_valid cycle and keeps the two previous
// rows in line buffers lb0 (row y-1) and lb1 (row y-2). For every interior
// position it presents the full 3x3 neighbourhood in parallel.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid          pixel strobe, always accepted (no backpressure)
//   in_sof            start of frame, qualified by in_valid; pixel becomes (0,0)
//   in_pix            raster-order pixel
//   out_valid         one-cycle pulse, window outputs valid
//   w00..w22          window pixels wRC (row R, column C); w00 oldest, w22 newest
//   out_x, out_y      coordinates of the window centre
//
// Optional feature: define SOBEL_WIN_OUTREG_EN to add one more register stage on
// all outputs (2-cycle latency instead of 1).
module sobel_window_gen #(
    parameter int unsigned PIX_WIDTH  = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [PIX_WIDTH-1:0]          in_pix,
    output logic                          out_valid,
    output logic [PIX_WIDTH-1:0]          w00,
    output logic [PIX_WIDTH-1:0]          w01,
    output logic [PIX_WIDTH-1:0]          w02,
    output logic [PIX_WIDTH-1:0]          w10,
    output logic [PIX_WIDTH-1:0]          w11,
    output logic [PIX_WIDTH-1:0]          w12,
    output logic [PIX_WIDTH-1:0]          w20,
    output logic [PIX_WIDTH-1:0]          w21,
    output logic [PIX_WIDTH-1:0]          w22,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_y
);

    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);
    localparam int unsigned NW = 9;

    logic [XW-1:0]        x_q, xe;
    logic [YW-1:0]        y_q, ye;
    logic [PIX_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [PIX_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [PIX_WIDTH-1:0] rd0, rd1;
    // Window columns 1 and 2 (index = row); column 0 is implied by the shift.
    logic [PIX_WIDTH-1:0] c1 [3];
    logic [PIX_WIDTH-1:0] c2 [3];
    // Window as it stands after the current pixel is accepted, row-major.
    logic [PIX_WIDTH-1:0] nxt [NW];
    logic                 win_ok;

    // Effective position of the incoming pixel; in_sof forces (0,0).
    always_comb begin
        xe  = in_sof ? '0 : x_q;
        ye  = in_sof ? '0 : y_q;
        rd0 = lb0[xe];
        rd1 = lb1[xe];
        win_ok = (xe >= XW'(2)) && (ye >= YW'(2));
        nxt[0] = c1[0];
        nxt[1] = c2[0];
        nxt[2] = rd1;
        nxt[3] = c1[1];
        nxt[4] = c2[1];
        nxt[5] = rd0;
        nxt[6] = c1[2];
        nxt[7] = c2[2];
        nxt[8] = in_pix;
    end

    // Line buffers: read-before-write at the same address via non-blocking update.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1[xe] <= rd0;
            lb0[xe] <= in_pix;
        end
    end

    // Position counters and window shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            for (int i = 0; i < 3; i++) begin
                c1[i] <= '0;
                c2[i] <= '0;
            end
        end else if (in_valid) begin
            if (xe == XW'(IMG_WIDTH - 1)) begin
                x_q <= '0;
                y_q <= (ye == YW'(IMG_HEIGHT - 1)) ? '0 : ye + YW'(1);
            end else begin
                x_q <= xe + XW'(1);
                y_q <= ye;
            end
            for (int i = 0; i < 3; i++) begin
                c1[i] <= c2[i];
            end
            c2[0] <= rd1;
            c2[1] <= rd0;
            c2[2] <= in_pix;
        end
    end

    // First output stage: loads only on valid windows, holds otherwise.
    logic                 s1_valid;
    logic [PIX_WIDTH-1:0] s1_w [NW];
    logic [XW-1:0]        s1_x;
    logic [YW-1:0]        s1_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            for (int i = 0; i < NW; i++) begin
                s1_w[i] <= '0;
            end
        end else begin
            s1_valid <= in_valid && win_ok;
            if (in_valid && win_ok) begin
                s1_x <= xe - XW'(1);
                s1_y <= ye - YW'(1);
                for (int i = 0; i < NW; i++) begin
                    s1_w[i] <= nxt[i];
                end
            end
        end
    end

    logic                 o_valid;
    logic [PIX_WIDTH-1:0] o_w [NW];
    logic [XW-1:0]        o_x;
    logic [YW-1:0]        o_y;

`ifdef SOBEL_WIN_OUTREG_EN
    // Extra retiming stage; s1 already holds between windows so a plain copy holds too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            for (int i = 0; i < NW; i++) begin
                o_w[i] <= '0;
            end
        end else begin
            o_valid <= s1_valid;
            o_x     <= s1_x;
            o_y     <= s1_y;
            for (int i = 0; i < NW; i++) begin
                o_w[i] <= s1_w[i];
            end
        end
    end
`else
    always_comb begin
        o_valid = s1_valid;
        o_x     = s1_x;
        o_y     = s1_y;
        for (int i = 0; i < NW; i++) begin
            o_w[i] = s1_w[i];
        end
    end
`endif

    assign out_valid = o_valid;
    assign out_x     = o_x;
    assign out_y     = o_y;
    assign w00       = o_w[0];
    assign w01       = o_w[1];
    assign w02       = o_w[2];
    assign w10       = o_w[3];
    assign w11       = o_w[4];
    assign w12       = o_w[5];
    assign w20       = o_w[6];
    assign w21       = o_w[7];
    assign w22       = o_w[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed testbench for sobel_window_gen with a 5x4 image, pixel = 10*y + x.
module tb_sobel_window_gen;

    localparam int unsigned PW = 8;
    localparam int unsigned IW = 5;
    localparam int unsigned IH = 4;
`ifdef SOBEL_WIN_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_sof;
    logic [PW-1:0] in_pix;
    logic          out_valid;
    logic [PW-1:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
    logic [2:0]    out_x;
    logic [1:0]    out_y;

    sobel_window_gen #(
        .PIX_WIDTH (PW),
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_pix   (in_pix),
        .out_valid(out_valid),
        .w00      (w00),
        .w01      (w01),
        .w02      (w02),
        .w10      (w10),
        .w11      (w11),
        .w12      (w12),
        .w20      (w20),
        .w21      (w21),
        .w22      (w22),
        .out_x    (out_x),
        .out_y    (out_y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          nvec = 0;
    int          nerr = 0;
    int          acc = 0;
    int          idle_viol = 0;
    logic [76:0] q[$];
    int          qa[$];
    logic [1:0]  vh = '0;
    logic        v0_m;

    // Capture every window pulse as {out_x, out_y, w00..w22}, with pixels accepted so far.
    always @(posedge clk) begin
        v0_m = in_valid;
        if (in_valid) acc = acc + 1;
        #1;
        vh = {vh[0], v0_m};
        if (out_valid) begin
            q.push_back({out_x, out_y, w00, w01, w02, w10, w11, w12, w20, w21, w22});
            qa.push_back(acc);
            if (!vh[LAT-1]) idle_viol = idle_viol + 1;
        end
    end

    // Expected k-th window of a frame: centres (1,1),(2,1),(3,1),(1,2),(2,2),(3,2).
    function automatic logic [76:0] exp_win(input int k);
        logic [76:0] r;
        int cx, cy;
        cx = 1 + (k % 3);
        cy = 1 + (k / 3);
        r[76:74] = 3'(cx);
        r[73:72] = 2'(cy);
        for (int rr = 0; rr < 3; rr++)
            for (int c = 0; c < 3; c++)
                r[71 - 8*(3*rr + c) -: 8] = 8'(10*(cy - 1 + rr) + (cx - 1 + c));
        return r;
    endfunction

    task automatic drive(input logic [PW-1:0] p, input logic sof);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pix   = p;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic send_frame(input int gap, input logic sof_first);
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) begin
                if (gap > 0) idle(int'($urandom_range(0, gap)));
                drive(PW'(10*y + x), sof_first && (x == 0) && (y == 0));
            end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0;
        repeat (3) @(negedge clk);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        nvec++; if ({w00, w01, w02, w10, w11, w12, w20, w21, w22} !== 72'h0) begin nerr++;
            $display("FAIL reset_w: got %h expected 0", {w00, w01, w02, w10, w11, w12, w20, w21, w22}); end
        nvec++; if (out_x !== 3'd0) begin nerr++; $display("FAIL reset_x: got %0d expected 0", out_x); end
        nvec++; if (out_y !== 2'd0) begin nerr++; $display("FAIL reset_y: got %0d expected 0", out_y); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_frame;
        int base;
        q.delete(); qa.delete();
        base = acc;
        send_frame(0, 1'b1);
        idle(4);
        nvec++; if (q.size() !== 6) begin nerr++; $display("FAIL frame_count: got %0d expected 6", q.size()); end
        if (q.size() >= 1) begin
            nvec++; if (q[0][71:0] !== 72'h0001020a0b0c141516) begin nerr++;
                $display("FAIL frame_first_w: got %h expected 0001020a0b0c141516", q[0][71:0]); end
            nvec++; if (q[0][76:72] !== {3'd1, 2'd1}) begin nerr++;
                $display("FAIL frame_first_xy: got %h expected %h", q[0][76:72], {3'd1, 2'd1}); end
            nvec++; if (qa[0] - base !== 13 + LAT - 1) begin nerr++;
                $display("FAIL frame_first_latency: got %0d pixels expected %0d", qa[0] - base, 13 + LAT - 1); end
        end
        if (q.size() >= 6) begin
            nvec++; if (q[5][71:0] !== 72'h0c0d0e161718202122) begin nerr++;
                $display("FAIL frame_last_w: got %h expected 0c0d0e161718202122", q[5][71:0]); end
            nvec++; if (q[5][76:72] !== {3'd3, 2'd2}) begin nerr++;
                $display("FAIL frame_last_xy: got %h expected %h", q[5][76:72], {3'd3, 2'd2}); end
        end
        for (int k = 0; k < q.size() && k < 6; k++) begin
            nvec++; if (q[k] !== exp_win(k)) begin nerr++;
                $display("FAIL frame_win[%0d]: got %h expected %h", k, q[k], exp_win(k)); end
        end
    endtask

    task automatic test_gaps;
        int base_viol;
        q.delete(); qa.delete();
        base_viol = idle_viol;
        send_frame(3, 1'b1);
        idle(4);
        nvec++; if (q.size() !== 6) begin nerr++; $display("FAIL gaps_count: got %0d expected 6", q.size()); end
        for (int k = 0; k < q.size() && k < 6; k++) begin
            nvec++; if (q[k] !== exp_win(k)) begin nerr++;
                $display("FAIL gaps_win[%0d]: got %h expected %h", k, q[k], exp_win(k)); end
        end
        nvec++; if (idle_viol - base_viol !== 0) begin nerr++;
            $display("FAIL gaps_idle_pulse: got %0d pulses on idle cycles expected 0", idle_viol - base_viol); end
    endtask

    task automatic test_back_to_back;
        q.delete(); qa.delete();
        send_frame(0, 1'b1);
        send_frame(0, 1'b1);
        idle(4);
        nvec++; if (q.size() !== 12) begin nerr++; $display("FAIL b2b_count: got %0d expected 12", q.size()); end
        for (int k = 0; k < q.size() && k < 12; k++) begin
            nvec++; if (q[k] !== exp_win(k % 6)) begin nerr++;
                $display("FAIL b2b_win[%0d]: got %h expected %h", k, q[k], exp_win(k % 6)); end
        end
    endtask

    task automatic test_sof_resync;
        q.delete(); qa.delete();
        // Partial frame up to (2,1); next pixel would be (3,1) but carries in_sof.
        for (int i = 0; i < 8; i++)
            drive(PW'(10*(i / IW) + (i % IW)), i == 0);
        send_frame(0, 1'b1);
        idle(4);
        nvec++; if (q.size() !== 6) begin nerr++; $display("FAIL sof_count: got %0d expected 6", q.size()); end
        for (int k = 0; k < q.size() && k < 6; k++) begin
            nvec++; if (q[k] !== exp_win(k)) begin nerr++;
                $display("FAIL sof_win[%0d]: got %h expected %h", k, q[k], exp_win(k)); end
        end
    endtask

    task automatic test_reset_mid;
        q.delete(); qa.delete();
        // Pixels 0..21, i.e. up to position (1,2): no window yet.
        for (int i = 0; i < 12; i++)
            drive(PW'(10*(i / IW) + (i % IW)), i == 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        nvec++; if ({w00, w01, w02, w10, w11, w12, w20, w21, w22} !== 72'h0) begin nerr++;
            $display("FAIL rstmid_w: got %h expected 0", {w00, w01, w02, w10, w11, w12, w20, w21, w22}); end
        nvec++; if ({out_x, out_y} !== 5'd0) begin nerr++; $display("FAIL rstmid_xy: got %h expected 0", {out_x, out_y}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete(); qa.delete();
        // Clean frame without in_sof: reset alone must restart at (0,0).
        send_frame(0, 1'b0);
        idle(4);
        nvec++; if (q.size() !== 6) begin nerr++; $display("FAIL rstmid_count: got %0d expected 6", q.size()); end
        for (int k = 0; k < q.size() && k < 6; k++) begin
            nvec++; if (q[k] !== exp_win(k)) begin nerr++;
                $display("FAIL rstmid_win[%0d]: got %h expected %h", k, q[k], exp_win(k)); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_gaps();
        test_back_to_back();
        test_sof_resync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
